// File: rtl/bf16_mul_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : bf16_mul_scheduler
//  Brief    : Four-requester round-robin front end for a two-stage bf16
//             multiplier with a single backpressured result port.
//  Revision : 1.0 - initial release
// ============================================================================
module bf16_mul_scheduler #(
    parameter int ROUND_EN = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  req_valid,
    input  logic [63:0] req_a,
    input  logic [63:0] req_b,
    output logic [3:0]  req_ready,
    output logic        resp_valid,
    output logic [15:0] resp_y,
    output logic [1:0]  resp_id,
    input  logic        resp_ready,
    output logic [1:0]  occupancy
);

    localparam logic [1:0] c_PTR_RESET = 2'd3;
    localparam logic [7:0] c_EXP_BIAS  = 8'd127;

    logic [1:0]  r_last;
    logic        r_s1_valid;
    logic [15:0] r_s1_a;
    logic [15:0] r_s1_b;
    logic [1:0]  r_s1_id;
    logic        r_resp_valid;
    logic [15:0] r_resp_y;
    logic [1:0]  r_resp_id;

    logic        w_en;
    logic [3:0]  w_grant;
    logic [1:0]  w_grant_id;
    logic        w_grant_any;
    logic        w_accept;
    logic [15:0] w_sel_a;
    logic [15:0] w_sel_b;

    logic        w_sign;
    logic        w_zero;
    logic [15:0] w_prod;
    logic [7:0]  w_exp_sum;
    logic [6:0]  w_mant;
    logic [7:0]  w_exp;
    logic        w_guard;
    logic        w_sticky;
    logic        w_round_up;
    logic [7:0]  w_mant_inc;
    logic [6:0]  w_mant_r;
    logic [7:0]  w_exp_r;
    logic [15:0] w_y;

    // The whole pipeline freezes only when a held result is not being taken.
    assign w_en = !(r_resp_valid && !resp_ready);

    always_comb begin : arbiter
        logic [1:0] v_idx;
        w_grant     = 4'b0000;
        w_grant_id  = 2'd0;
        w_grant_any = 1'b0;
        v_idx       = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            v_idx = r_last + 2'(k);
            if (!w_grant_any && req_valid[v_idx]) begin
                w_grant_any     = 1'b1;
                w_grant_id      = v_idx;
                w_grant[v_idx]  = 1'b1;
            end
        end
    end

    assign req_ready = (w_en && !reset) ? w_grant : 4'b0000;
    assign w_accept  = |req_ready;
    assign w_sel_a   = req_a[16*w_grant_id +: 16];
    assign w_sel_b   = req_b[16*w_grant_id +: 16];

    assign w_sign    = r_s1_a[15] ^ r_s1_b[15];
    assign w_zero    = (r_s1_a[14:0] == 15'd0) || (r_s1_b[14:0] == 15'd0);
    assign w_prod    = 16'({1'b1, r_s1_a[6:0]}) * 16'({1'b1, r_s1_b[6:0]});
    assign w_exp_sum = r_s1_a[14:7] + r_s1_b[14:7] - c_EXP_BIAS;

    always_comb begin
        w_mant     = w_prod[13:7];
        w_guard    = w_prod[6];
        w_sticky   = |w_prod[5:0];
        w_exp      = w_exp_sum;
        if (w_prod[15]) begin
            w_mant   = w_prod[14:8];
            w_guard  = w_prod[7];
            w_sticky = |w_prod[6:0];
            w_exp    = w_exp_sum + 8'd1;
        end
        w_round_up = (ROUND_EN != 0) && w_guard && (w_sticky || w_mant[0]);
        w_mant_inc = {1'b0, w_mant} + 8'd1;
        w_mant_r   = w_mant;
        w_exp_r    = w_exp;
        // A mantissa carry-out renormalises to 1.0 x 2^(E+1).
        if (w_round_up) begin
            w_mant_r = w_mant_inc[6:0];
            if (w_mant_inc[7]) begin
                w_mant_r = 7'd0;
                w_exp_r  = w_exp + 8'd1;
            end
        end
        w_y = w_zero ? {w_sign, 15'd0} : {w_sign, w_exp_r, w_mant_r};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_last       <= c_PTR_RESET;
            r_s1_valid   <= 1'b0;
            r_s1_a       <= 16'd0;
            r_s1_b       <= 16'd0;
            r_s1_id      <= 2'd0;
            r_resp_valid <= 1'b0;
            r_resp_y     <= 16'd0;
            r_resp_id    <= 2'd0;
        end else if (w_en) begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_a  <= w_sel_a;
                r_s1_b  <= w_sel_b;
                r_s1_id <= w_grant_id;
                r_last  <= w_grant_id;
            end
            r_resp_valid <= r_s1_valid;
            r_resp_y     <= w_y;
            r_resp_id    <= r_s1_id;
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_y     = r_resp_y;
    assign resp_id    = r_resp_id;
    assign occupancy  = {1'b0, r_s1_valid} + {1'b0, r_resp_valid};

endmodule
`default_nettype wire
